// File: rtl/bist_alu_session.sv
// bist_alu_session
//
// Self-contained BIST session around a small registered ALU. An internal LFSR
// produces N_PATTERNS operands. The ALU runs one operation on the current
// pattern (a) and the previous pattern (b). That operation is chosen by `op`
// when the session starts. Every ALU result is compacted into a MISR. At the
// end of the session the signature is compared with GOLDEN.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-low reset
//   start         session start; only honoured in IDLE or DONE
//   op[2:0]       ALU operation, latched when start is accepted
//   busy          high while the session runs (RUN and FLUSH)
//   done          high in DONE
//   pass          valid while done: signature == GOLDEN
//   result        registered ALU result, zero-extended to 2*WIDTH
//   result_valid  result holds a session result this cycle
//   signature     MISR contents
module bist_alu_session #(
    parameter int unsigned           WIDTH      = 8,
    parameter int unsigned           N_PATTERNS = 255,
    parameter logic [WIDTH-1:0]      LFSR_SEED  = 8'h01,
    parameter logic [WIDTH-1:0]      LFSR_TAPS  = 8'hB8,
    parameter logic [2*WIDTH-1:0]    MISR_TAPS  = 16'hB400,
    parameter int unsigned           SHIFT      = 2,
    parameter logic [2*WIDTH-1:0]    GOLDEN     = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    output logic [2*WIDTH-1:0]   signature
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_PATTERNS - 1);
    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  lfsr_reg, a_reg, b_reg;
    logic [W2-1:0]     misr_reg;
    logic [CW-1:0]     cnt_reg;
    logic              fcnt_reg;
    logic              v0_reg;
    logic [2:0]        op_reg;

    logic              load;
    logic              enter_done;
    logic [WIDTH-1:0]  lfsr_next;
    logic [W2-1:0]     misr_next;
    logic [W2-1:0]     alu_out;

    // ALU intermediates are kept at their natural widths before zero-extension.
    // If the inversions ran in a 2*WIDTH context, the upper half would fill with ones.
    logic [WIDTH:0]    alu_sum, alu_diff;
    logic [W2-1:0]     alu_prod;
    logic [WIDTH-1:0]  alu_xor, alu_xnor, alu_nand, alu_shl, alu_shr;

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        enter_done = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (cnt_reg == CNT_LAST) state_next = FLUSH;
            end
            FLUSH: begin
                // Two flush edges drain a_reg -> result -> MISR.
                if (fcnt_reg) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_next = {lfsr_reg[WIDTH-2:0], ^(lfsr_reg & LFSR_TAPS)};
        misr_next = {misr_reg[W2-2:0], ^(misr_reg & MISR_TAPS)} ^ result;
    end

    always_comb begin
        alu_sum  = {1'b0, a_reg} + {1'b0, b_reg};
        alu_diff = {1'b0, a_reg} - {1'b0, b_reg};
        alu_prod = a_reg * b_reg;
        alu_xor  = a_reg ^ b_reg;
        alu_xnor = ~(a_reg ^ b_reg);
        alu_nand = ~(a_reg & b_reg);
        alu_shl  = a_reg << SHIFT;
        alu_shr  = a_reg >> SHIFT;
        alu_out  = '0;
        case (op_reg)
            3'd0:    alu_out = {{(WIDTH-1){1'b0}}, alu_sum};
            3'd1:    alu_out = {{(WIDTH-1){1'b0}}, alu_diff};
            3'd2:    alu_out = alu_prod;
            3'd3:    alu_out = {{WIDTH{1'b0}}, alu_xor};
            3'd4:    alu_out = {{WIDTH{1'b0}}, alu_xnor};
            3'd5:    alu_out = {{WIDTH{1'b0}}, alu_nand};
            3'd6:    alu_out = {{WIDTH{1'b0}}, alu_shl};
            default: alu_out = {{WIDTH{1'b0}}, alu_shr};
        endcase
    end

    // ------------------------------------------------------------------
    // Session registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_reg     <= SEED_EFF;
            a_reg        <= '0;
            b_reg        <= '0;
            misr_reg     <= '0;
            cnt_reg      <= '0;
            fcnt_reg     <= 1'b0;
            v0_reg       <= 1'b0;
            op_reg       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else if (load) begin
            lfsr_reg     <= SEED_EFF;
            a_reg        <= '0;
            b_reg        <= '0;
            misr_reg     <= '0;
            cnt_reg      <= '0;
            fcnt_reg     <= 1'b0;
            v0_reg       <= 1'b0;
            op_reg       <= op;
            result_valid <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            if (state_reg == RUN) begin
                a_reg    <= lfsr_reg;
                b_reg    <= a_reg;
                lfsr_reg <= lfsr_next;
                cnt_reg  <= cnt_reg + 1'b1;
                v0_reg   <= 1'b1;
                fcnt_reg <= 1'b0;
            end
            if (state_reg == FLUSH) begin
                v0_reg   <= 1'b0;
                fcnt_reg <= ~fcnt_reg;
            end
            // Result only moves for real patterns, so it holds otherwise.
            if (v0_reg) result <= alu_out;
            result_valid <= v0_reg;
            if (result_valid) misr_reg <= misr_next;
            // The final absorb happens on this same edge, so compare the
            // updated signature rather than the stale register.
            if (enter_done) begin
                done <= 1'b1;
                pass <= ((result_valid ? misr_next : misr_reg) == GOLDEN);
            end
        end
    end

    assign busy      = (state_reg == RUN) || (state_reg == FLUSH);
    assign signature = misr_reg;

endmodule

// File: tb/tb_bist_alu_session.sv
// Directed bench for bist_alu_session. Six instances with different
// parameter sets share one clock and one reset. Each instance has its own start and op.
module tb_bist_alu_session;

    localparam int NI = 6;

    function automatic int p_n(input int i);
        case (i)
            0: return 3;  1: return 4;  2: return 2;
            3: return 1;  4: return 1;  default: return 3;
        endcase
    endfunction

    function automatic int p_seed(input int i);
        case (i)
            2: return 'h80;
            5: return 'h00;
            default: return 'h01;
        endcase
    endfunction

    function automatic int p_gold(input int i);
        case (i)
            3: return 'h0001;
            4: return 'h0002;
            default: return 'h0000;
        endcase
    endfunction

    logic            clk;
    logic            reset;
    logic [NI-1:0]   start;
    logic [2:0]      op       [NI];
    logic [NI-1:0]   busy, done, pass, rv;
    logic [15:0]     result   [NI];
    logic [15:0]     sig      [NI];

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int          NP = p_n(gi);
            localparam logic [7:0]  SD = 8'(p_seed(gi));
            localparam logic [15:0] GD = 16'(p_gold(gi));
            bist_alu_session #(
                .WIDTH(8), .N_PATTERNS(NP), .LFSR_SEED(SD),
                .LFSR_TAPS(8'hB8), .MISR_TAPS(16'hB400), .SHIFT(2), .GOLDEN(GD)
            ) u_dut (
                .clk(clk), .reset(reset), .start(start[gi]), .op(op[gi]),
                .busy(busy[gi]), .done(done[gi]), .pass(pass[gi]),
                .result(result[gi]), .result_valid(rv[gi]), .signature(sig[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          busy_cnt;
    int          done_cyc;
    logic [15:0] res_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
    endtask

    function automatic logic [15:0] res_at(input int k);
        if (res_q.size() > k) return res_q[k];
        return 16'hxxxx;
    endfunction

    // Start a session on instance i. Count busy cycles and record each valid
    // result. Note the cycle (edges after the start edge) at which done is first
    // seen. The wait is bounded at 40 edges.
    task automatic run_session(input int i, input logic [2:0] o, input int pulse_at, input bit hold);
        @(negedge clk);
        op[i]    = o;
        start[i] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start[i] = 1'b0;
        busy_cnt = busy[i] ? 1 : 0;
        done_cyc = -1;
        res_q.delete();
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            if (pulse_at == c) start[i] = 1'b1;
            else if (!hold)    start[i] = 1'b0;
            @(posedge clk); #1;
            if (busy[i]) busy_cnt++;
            if (rv[i]) res_q.push_back(result[i]);
            if (done[i]) done_cyc = c;
        end
        if (!hold) start[i] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = '0;
        for (int i = 0; i < NI; i++) op[i] = 3'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy[0]),   32'h0);
        chk("rst_done",   32'(done[0]),   32'h0);
        chk("rst_pass",   32'(pass[0]),   32'h0);
        chk("rst_result", 32'(result[0]), 32'h0);
        chk("rst_rv",     32'(rv[0]),     32'h0);
        chk("rst_sig",    32'(sig[0]),    32'h0);
        @(negedge clk);
        reset = 1'b1;

        // op0 add, N=3: patterns 01,02,04 -> 0001,0003,0006; signature 0004
        run_session(0, 3'd0, -1, 1'b0);
        chk("add_nres",   32'(res_q.size()), 32'd3);
        chk("add_r0",     32'(res_at(0)), 32'h0001);
        chk("add_r1",     32'(res_at(1)), 32'h0003);
        chk("add_r2",     32'(res_at(2)), 32'h0006);
        chk("add_donecy", 32'(done_cyc),  32'd5);
        chk("add_busycy", 32'(busy_cnt),  32'd5);
        chk("add_sig",    32'(sig[0]),    32'h0004);
        chk("add_pass",   32'(pass[0]),   32'h0);
        chk("add_rvlow",  32'(rv[0]),     32'h0);

        // op2 mul, N=4: 0000,0002,0008,0020; signature 0038
        run_session(1, 3'd2, -1, 1'b0);
        chk("mul_nres", 32'(res_q.size()), 32'd4);
        chk("mul_r0",   32'(res_at(0)), 32'h0000);
        chk("mul_r1",   32'(res_at(1)), 32'h0002);
        chk("mul_r2",   32'(res_at(2)), 32'h0008);
        chk("mul_r3",   32'(res_at(3)), 32'h0020);
        chk("mul_sig",  32'(sig[1]),    32'h0038);
        chk("mul_hold", 32'(result[1]), 32'h0020);

        // op1 sub, seed 80, N=2: 0080 then 0181; signature 0081
        run_session(2, 3'd1, -1, 1'b0);
        chk("sub_r0",  32'(res_at(0)), 32'h0080);
        chk("sub_r1",  32'(res_at(1)), 32'h0181);
        chk("sub_sig", 32'(sig[2]),    32'h0081);

        // N=1 golden match / mismatch
        run_session(3, 3'd0, -1, 1'b0);
        chk("g1_sig",    32'(sig[3]),   32'h0001);
        chk("g1_pass",   32'(pass[3]),  32'h1);
        chk("g1_donecy", 32'(done_cyc), 32'd3);
        run_session(4, 3'd0, -1, 1'b0);
        chk("g2_sig",  32'(sig[4]),  32'h0001);
        chk("g2_pass", 32'(pass[4]), 32'h0);

        // op6 shift-left by 2: 0004,0008,0010; signature 0010
        run_session(0, 3'd6, -1, 1'b0);
        chk("shl_r0",  32'(res_at(0)), 32'h0004);
        chk("shl_r2",  32'(res_at(2)), 32'h0010);
        chk("shl_sig", 32'(sig[0]),    32'h0010);

        // Reset for one cycle mid-RUN
        @(negedge clk);
        op[0]    = 3'd0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_result_pre", 32'(result[0]), 32'h0001);
        reset = 1'b0;
        #1;
        chk("ab_busy",   32'(busy[0]),   32'h0);
        chk("ab_result", 32'(result[0]), 32'h0);
        chk("ab_rv",     32'(rv[0]),     32'h0);
        chk("ab_sig",    32'(sig[0]),    32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_session(0, 3'd0, -1, 1'b0);
        chk("ab_rerun_sig", 32'(sig[0]), 32'h0004);

        // Start pulsed during RUN is ignored
        run_session(0, 3'd0, 2, 1'b0);
        chk("pulse_donecy", 32'(done_cyc), 32'd5);
        chk("pulse_sig",    32'(sig[0]),   32'h0004);

        // Start held through DONE restarts the session
        run_session(0, 3'd0, -1, 1'b1);
        chk("hold_done", 32'(done[0]), 32'h1);
        @(posedge clk); #1;
        chk("hold_restart_done", 32'(done[0]), 32'h0);
        chk("hold_restart_busy", 32'(busy[0]), 32'h1);
        chk("hold_restart_sig",  32'(sig[0]),  32'h0);
        start[0] = 1'b0;
        for (int c = 0; c < 20 && !done[0]; c++) begin @(posedge clk); #1; end
        chk("hold_done2", 32'(done[0]), 32'h1);
        chk("hold_sig2",  32'(sig[0]),  32'h0004);

        // Zero seed behaves like seed 1
        run_session(5, 3'd0, -1, 1'b0);
        chk("seed0_r0",  32'(res_at(0)), 32'h0001);
        chk("seed0_r2",  32'(res_at(2)), 32'h0006);
        chk("seed0_sig", 32'(sig[5]),    32'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bist_alu_session.md
Name: bist_alu_session

Overview:
- Parametrised successor to the fixed 8-bit LFSR-driven ALU circuit-under-test.
- Runs a self-contained BIST session: an internal LFSR generates N_PATTERNS operands, a registered ALU applies one start-selected operation, and a MISR compacts every result.
- At session end the signature is compared against a golden value and reported as pass/fail.
- Sits beneath the BIST controller as one test target.

Parameters:
- WIDTH, 8, operand width (>=4).
- N_PATTERNS, 255, patterns per session (>=1).
- LFSR_SEED, 8'h01 (WIDTH bits), LFSR start value; if 0, 1 is used instead.
- LFSR_TAPS, 8'hB8 (WIDTH bits), feedback mask.
- MISR_TAPS, 16'hB400 (2*WIDTH bits), MISR feedback mask.
- SHIFT, 2, shift amount for ops 6/7 (< WIDTH).
- GOLDEN, 0 (2*WIDTH bits), expected signature.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  session start; sampled only in IDLE or DONE.
- op  in  3  ALU operation; latched at accepted start.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  high in DONE.
- pass  out  1  valid while done; signature==GOLDEN.
- result  out  2*WIDTH  registered ALU result.
- result_valid  out  1  result holds a session result this cycle.
- signature  out  2*WIDTH  MISR contents.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, pass, result, result_valid, signature all 0; op latch 0; lfsr=seed; a_reg=b_reg=0; counters 0.
- Reset asserted mid-session aborts immediately to the reset state. No partial signature survives.
- LFSR step: next = {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS)}.
- MISR step (when absorbing): next = {misr[2W-2:0], ^(misr & MISR_TAPS)} ^ result.
- ALU operands: a=a_reg (current pattern), b=b_reg (previous pattern). Results are zero-extended to 2W.
  - op 0: a+b, carry in bit W.
  - op 1: a-b, modulo 2^(W+1); borrow in bit W.
  - op 2: a*b, full 2W bits.
  - op 3: a^b.
  - op 4: ~(a^b), W bits.
  - op 5: ~(a&b), W bits.
  - op 6: (a<<SHIFT), truncated to W bits.
  - op 7: a>>SHIFT.
- FSM IDLE/DONE -> RUN on the edge where start=1:
  - lfsr<=seed, misr<=0, a_reg<=0, b_reg<=0, cnt<=0, op latched.
  - done, pass, result_valid <= 0.
  - Restart directly from DONE is legal.
- RUN, every edge:
  - a_reg<=lfsr; b_reg<=a_reg; lfsr steps; cnt++; v0<=1.
  - When cnt==N_PATTERNS-1 -> FLUSH with fcnt=0.
  - start is ignored.
- Pipeline, every edge:
  - result<=alu(a_reg,b_reg); result_valid<=v0.
  - MISR absorbs when result_valid=1.
- FLUSH: v0<=0; lasts 2 edges, then DONE. The last absorb coincides with the DONE transition.
- Latency: pattern k (k=1..N) enters a_reg at edge k, result at edge k+1, MISR at edge k+2. The first pattern's b is 0. done rises after edge N+2 counted from the start edge (edge 0).
- DONE: done=1; pass=(signature==GOLDEN) registered on entry; signature frozen; waits for start.
- result holds its last value when result_valid=0.

Test Plan:
- WIDTH=8, seed 0x01, op=0, N=3 -> patterns 01,02,04; result 0x0001, 0x0003, 0x0006 on 3 consecutive result_valid cycles; done high 5 cycles after start edge; busy exactly 5 cycles.
- op=2, N=4, seed 0x01 -> results 0x0000, 0x0002, 0x0008, 0x0020 (patterns 01,02,04,08).
- op=1, seed 0x80, N=2 -> patterns 80,01; results 0x0080 then 0x0181 (01-80, borrow bit 8 set).
- op=0, N=1, seed 0x01, GOLDEN=0x0001 -> signature 0x0001, pass=1; rerun with GOLDEN=0x0002 -> pass=0.
- Assert reset for 1 cycle mid-RUN -> all outputs 0 immediately, IDLE; fresh start reproduces the uninterrupted signature.
- Start held high through DONE -> session restarts next edge; done drops, identical signature regenerated. Start pulsed during RUN -> no effect. LFSR_SEED=0 -> identical behaviour to seed 1.
